eth_frame_buf: RTL and testbench

- Double-buffered (ping-pong) acquisition frame store directly upstream of the Ethernet UDP sender.
- The acquisition side streams 32-bit words into the fill bank. On each measurement-sync falling edge, the filled bank is published to the sender.
- The sender reads the published bank by word address (1-cycle latency), then releases it with a done pulse.

---
 rtl/eth_frame_buf_pkg.sv | 23 ++
 rtl/eth_frame_buf_if.sv | 30 +++
 rtl/eth_frame_buf_dpram.sv | 35 +++
 rtl/eth_frame_buf.sv | 186 ++++++++++++++++++
 tb/tb_eth_frame_buf.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/eth_frame_buf_pkg.sv
// Shared types and constants for the ping-pong acquisition frame store.
// Header layout constants are used only when ETH_FRAME_HDR_EN is defined.
package eth_frame_buf_pkg;

  typedef enum logic [1:0] {
    StWaitSync,
    StFill,
    StFull
  } state_e;

  localparam int unsigned SEQ_W = 16;
  localparam int unsigned HDR_W = 32;
  localparam int unsigned HDR_LEN_W = HDR_W - SEQ_W;

  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  // Header word: sequence in the upper half, zero-extended length in the lower half.
  function automatic logic [HDR_W-1:0] hdr_word(input logic [SEQ_W-1:0] seq,
                                                input logic [HDR_LEN_W-1:0] len);
    return {seq, len};
  endfunction

endpackage

// File: rtl/eth_frame_buf_if.sv
// Acquisition write stream and sender read port of eth_frame_buf.
// slave: the frame buffer; master: the surrounding logic.
interface eth_frame_buf_if
  import eth_frame_buf_pkg::*;
#(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
);

  logic [DW-1:0]    i_wr_data;
  logic             i_wr_vld;
  logic             o_wr_rdy;
  logic [AW-1:0]    i_rd_addr;
  logic [DW-1:0]    o_rd_data;
  logic             o_frame_rdy;
  logic [AW:0]      o_frame_len;
  logic [SEQ_W-1:0] o_frame_seq;
  logic             i_rd_done;

  modport slave (
    input  i_wr_data, i_wr_vld, i_rd_addr, i_rd_done,
    output o_wr_rdy, o_rd_data, o_frame_rdy, o_frame_len, o_frame_seq
  );

  modport master (
    output i_wr_data, i_wr_vld, i_rd_addr, i_rd_done,
    input  o_wr_rdy, o_rd_data, o_frame_rdy, o_frame_len, o_frame_seq
  );

endinterface

// File: rtl/eth_frame_buf_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
// Only the read output register is reset so the array still maps to block RAM.
module eth_dpram #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DW     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DW-1:0]     rdata
);

  logic [DW-1:0] mem [2**ADDR_W];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/eth_frame_buf.sv
// Ping-pong acquisition frame store feeding the UDP sender; publishes on msync falling edge.
// Define ETH_FRAME_HDR_EN to prepend a {seq, len} header word at read address 0.
module eth_frame_buf
  import eth_frame_buf_pkg::*;
#(
  parameter int unsigned AW          = 10,
  parameter int unsigned DW          = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_msync_n,
  eth_frame_buf_if.slave        bus,
  output logic [15:0]           o_drop_cnt,
  output logic                  o_ovf
);

`ifdef ETH_FRAME_HDR_EN
  localparam logic [AW-1:0] PTR_START = AW'(1);
`else
  localparam logic [AW-1:0] PTR_START = '0;
`endif

  // msync synchroniser and falling-edge detect
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   sync_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STAGES'(i_msync_n);
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_fall = hist_q & ~sync_q[SYNC_STAGES-1];

  // Write FSM and frame bookkeeping
  state_e           state_q, state_d;
  logic             fill_bank_q, fill_bank_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      wr_cnt_q, wr_cnt_d;
  logic             frame_rdy_q, frame_rdy_d;
  logic [AW:0]      frame_len_q, frame_len_d;
  logic [SEQ_W-1:0] frame_seq_q, frame_seq_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic             ovf_q, ovf_d;

  logic        wr_en;
  logic [AW:0] cnt_eff;
  logic        read_free;

  assign wr_en     = (state_q == StFill) && bus.i_wr_vld;
  // A word accepted alongside sync_fall still belongs to the closing frame.
  assign cnt_eff   = wr_cnt_q + {{AW{1'b0}}, wr_en};
  assign read_free = !frame_rdy_q || bus.i_rd_done;

  always_comb begin
    state_d     = state_q;
    fill_bank_d = fill_bank_q;
    wr_ptr_d    = wr_ptr_q;
    wr_cnt_d    = wr_cnt_q;
    frame_rdy_d = frame_rdy_q;
    frame_len_d = frame_len_q;
    frame_seq_d = frame_seq_q;
    drop_cnt_d  = drop_cnt_q;
    ovf_d       = ovf_q;

    if (bus.i_rd_done) begin
      frame_rdy_d = 1'b0;
    end

    unique case (state_q)
      StWaitSync: begin
        if (sync_fall) begin
          state_d  = StFill;
          wr_ptr_d = PTR_START;
          wr_cnt_d = '0;
        end
      end
      StFill: begin
        if (wr_en) begin
          wr_ptr_d = wr_ptr_q + AW'(1);
          wr_cnt_d = cnt_eff;
          if (wr_ptr_q == '1) begin
            state_d = StFull;
          end
        end
      end
      StFull: begin
        if (bus.i_wr_vld) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = StWaitSync;
    endcase

    if (sync_fall && (state_q != StWaitSync)) begin
      state_d  = StFill;
      wr_ptr_d = PTR_START;
      wr_cnt_d = '0;
      if (cnt_eff != '0) begin
        if (read_free) begin
          fill_bank_d = ~fill_bank_q;
          frame_len_d = cnt_eff;
          frame_seq_d = frame_seq_q + SEQ_W'(1);
          frame_rdy_d = 1'b1;
        end else if (drop_cnt_q != DROP_MAX) begin
          // Held read bank: the fill bank is simply rewritten from the start.
          drop_cnt_d = drop_cnt_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StWaitSync;
      fill_bank_q <= 1'b0;
      wr_ptr_q    <= '0;
      wr_cnt_q    <= '0;
      frame_rdy_q <= 1'b0;
      frame_len_q <= '0;
      frame_seq_q <= '0;
      drop_cnt_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_bank_q <= fill_bank_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_cnt_q    <= wr_cnt_d;
      frame_rdy_q <= frame_rdy_d;
      frame_len_q <= frame_len_d;
      frame_seq_q <= frame_seq_d;
      drop_cnt_q  <= drop_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  // Frame storage: bank select is the address MSB
  logic [DW-1:0] ram_rdata;

  eth_dpram #(
    .ADDR_W (AW + 1),
    .DW     (DW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr ({fill_bank_q, wr_ptr_q}),
    .wdata (bus.i_wr_data),
    .raddr ({~fill_bank_q, bus.i_rd_addr}),
    .rdata (ram_rdata)
  );

`ifdef ETH_FRAME_HDR_EN
  // Header captured alongside the RAM read so both share one cycle of latency.
  logic          hdr_sel_q;
  logic [DW-1:0] hdr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_sel_q <= 1'b0;
      hdr_q     <= '0;
    end else begin
      hdr_sel_q <= (bus.i_rd_addr == '0);
      hdr_q     <= DW'(hdr_word(frame_seq_q, HDR_LEN_W'(frame_len_q)));
    end
  end

  assign bus.o_rd_data = hdr_sel_q ? hdr_q : ram_rdata;
`else
  assign bus.o_rd_data = ram_rdata;
`endif

  assign bus.o_wr_rdy    = (state_q == StFill);
  assign bus.o_frame_rdy = frame_rdy_q;
  assign bus.o_frame_len = frame_len_q;
  assign bus.o_frame_seq = frame_seq_q;
  assign o_drop_cnt      = drop_cnt_q;
  assign o_ovf           = ovf_q;

endmodule

// File: tb/tb_eth_frame_buf.sv
// Directed self-checking bench for eth_frame_buf (default build or ETH_FRAME_HDR_EN).
module tb_eth_frame_buf;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
`ifdef ETH_FRAME_HDR_EN
  localparam int unsigned BASE = 1;
`else
  localparam int unsigned BASE = 0;
`endif
  localparam int unsigned CAP = (1 << AW) - BASE;

  logic        clk = 1'b0;
  logic        rst;
  logic        msync_n;
  logic [15:0] drop_cnt;
  logic        ovf;

  eth_frame_buf_if #(.AW(AW), .DW(DW)) bus ();

  eth_frame_buf #(
    .AW          (AW),
    .DW          (DW),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_msync_n  (msync_n),
    .bus        (bus.slave),
    .o_drop_cnt (drop_cnt),
    .o_ovf      (ovf)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] d);
    bus.i_wr_data = d;
    bus.i_wr_vld  = 1'b1;
    step();
    bus.i_wr_vld  = 1'b0;
  endtask

  // Falling msync edge; publish happens on the 3rd edge, where rd_done is optionally pulsed.
  task automatic sync_pulse(input logic done);
    msync_n = 1'b0;
    step();
    step();
    bus.i_rd_done = done;
    step();
    bus.i_rd_done = 1'b0;
    msync_n = 1'b1;
    repeat (3) step();
  endtask

  task automatic rd_check(input string tag, input int unsigned addr, input logic [31:0] exp);
    bus.i_rd_addr = AW'(addr);
    step();
    check(tag, bus.o_rd_data, exp);
  endtask

  initial begin
    rst           = 1'b1;
    msync_n       = 1'b1;
    bus.i_wr_data = '0;
    bus.i_wr_vld  = 1'b0;
    bus.i_rd_addr = '0;
    bus.i_rd_done = 1'b0;
    repeat (3) step();

    check("rst_wr_rdy", bus.o_wr_rdy, 0);
    check("rst_rd_data", bus.o_rd_data, 0);
    check("rst_frame_rdy", bus.o_frame_rdy, 0);
    check("rst_frame_len", bus.o_frame_len, 0);
    check("rst_frame_seq", bus.o_frame_seq, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    step();
    check("wait_sync_rdy", bus.o_wr_rdy, 0);

    // Basic frame of five words
    sync_pulse(1'b0);
    check("fill_wr_rdy", bus.o_wr_rdy, 1);
    for (int i = 0; i < 5; i++) write_word(32'h11 + i);
    sync_pulse(1'b0);
    check("f1_rdy", bus.o_frame_rdy, 1);
    check("f1_len", bus.o_frame_len, 5);
    check("f1_seq", bus.o_frame_seq, 1);
    rd_check("f1_word2", BASE + 2, 32'h13);
    rd_check("f1_word4", BASE + 4, 32'h15);
`ifdef ETH_FRAME_HDR_EN
    rd_check("f1_hdr", 0, 32'h0001_0005);
`endif

    // Second frame while first still held: dropped
    write_word(32'hA1);
    write_word(32'hA2);
    sync_pulse(1'b0);
    check("drop_cnt", drop_cnt, 1);
    check("drop_seq", bus.o_frame_seq, 1);
    check("drop_len", bus.o_frame_len, 5);
    rd_check("drop_keep_a", BASE, 32'h11);

    // Release in the same cycle as the sync edge: swap still happens
    for (int i = 0; i < 3; i++) write_word(32'h31 + i);
    sync_pulse(1'b1);
    check("same_rdy", bus.o_frame_rdy, 1);
    check("same_len", bus.o_frame_len, 3);
    check("same_seq", bus.o_frame_seq, 2);
    check("same_drop", drop_cnt, 1);
    rd_check("same_word1", BASE + 1, 32'h32);

    // Two syncs with no words: nothing published or dropped
    sync_pulse(1'b0);
    sync_pulse(1'b0);
    check("empty_seq", bus.o_frame_seq, 2);
    check("empty_drop", drop_cnt, 1);
    check("empty_len", bus.o_frame_len, 3);

    // Release, then fill to capacity and overflow
    bus.i_rd_done = 1'b1;
    step();
    bus.i_rd_done = 1'b0;
    check("release_rdy", bus.o_frame_rdy, 0);
    for (int i = 0; i < int'(CAP); i++) begin
      if (i == int'(CAP) - 1) check("full_pre_rdy", bus.o_wr_rdy, 1);
      write_word(32'h1000 + i);
    end
    check("full_wr_rdy", bus.o_wr_rdy, 0);
    check("full_no_ovf", ovf, 0);
    write_word(32'hDEAD);
    check("full_ovf", ovf, 1);
    sync_pulse(1'b0);
    check("full_len", bus.o_frame_len, CAP);
    check("full_seq", bus.o_frame_seq, 3);
    rd_check("full_last", (1 << AW) - 1, 32'h1000 + CAP - 1);
    rd_check("full_first", BASE, 32'h1000);

    // Reset mid-fill
    write_word(32'h66);
    write_word(32'h67);
    rst = 1'b1;
    step();
    check("mid_rst_wr_rdy", bus.o_wr_rdy, 0);
    check("mid_rst_rd_data", bus.o_rd_data, 0);
    check("mid_rst_frame_rdy", bus.o_frame_rdy, 0);
    check("mid_rst_len", bus.o_frame_len, 0);
    check("mid_rst_seq", bus.o_frame_seq, 0);
    check("mid_rst_drop", drop_cnt, 0);
    check("mid_rst_ovf", ovf, 0);
    rst = 1'b0;
    step();
    write_word(32'h77);
    check("post_rst_ignored", bus.o_wr_rdy, 0);
    sync_pulse(1'b0);
    check("post_rst_no_pub", bus.o_frame_rdy, 0);
    write_word(32'h55);
    sync_pulse(1'b0);
    check("post_rst_len", bus.o_frame_len, 1);
    check("post_rst_seq", bus.o_frame_seq, 1);
    rd_check("post_rst_word", BASE, 32'h55);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
